// File: rtl/reg_rename_file.sv
// Architectural register file with a rename status table (dirty bit + ROB tag per register).
// Combinational operand reads resolve through commit bypass and ROB forwarding.
module reg_rename_file #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned REG_BIT  = 5,
    parameter int unsigned ROB_BIT  = 4,
    parameter int unsigned NUM_READ = 2
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         rdy_in,
    input  logic                         flush_in,
    input  logic                         commit_valid,
    input  logic [REG_BIT-1:0]           commit_reg,
    input  logic [XLEN-1:0]              commit_data,
    input  logic [ROB_BIT-1:0]           commit_tag,
    input  logic                         issue_valid,
    input  logic [REG_BIT-1:0]           issue_reg,
    input  logic [ROB_BIT-1:0]           issue_tag,
    input  logic [NUM_READ*REG_BIT-1:0]  rd_id,
    output logic [NUM_READ*XLEN-1:0]     rd_val,
    output logic [NUM_READ-1:0]          rd_has_dep,
    output logic [NUM_READ*ROB_BIT-1:0]  rd_dep,
    output logic [NUM_READ*ROB_BIT-1:0]  rob_qry_tag,
    input  logic [NUM_READ-1:0]          rob_qry_ready,
    input  logic [NUM_READ*XLEN-1:0]     rob_qry_value,
    output logic [REG_BIT:0]             busy_count
);

    logic [XLEN-1:0]    regs_q  [NUM_REGS];
    logic [XLEN-1:0]    regs_d  [NUM_REGS];
    logic [ROB_BIT-1:0] tag_q   [NUM_REGS];
    logic [ROB_BIT-1:0] tag_d   [NUM_REGS];
    logic [NUM_REGS-1:0] dirty_q, dirty_d;
    logic [REG_BIT:0]    busy_q, busy_d;

    logic commit_we, issue_we;

    assign commit_we = commit_valid && (commit_reg != '0);
    assign issue_we  = issue_valid && (issue_reg != '0);

    always_comb begin
        regs_d  = regs_q;
        tag_d   = tag_q;
        dirty_d = dirty_q;
        busy_d  = '0;

        // Commit always writes data; status clears only if no newer writer renamed the reg.
        if (commit_we) begin
            regs_d[commit_reg] = commit_data;
            if (tag_q[commit_reg] == commit_tag) begin
                dirty_d[commit_reg] = 1'b0;
                tag_d[commit_reg]   = '0;
            end
        end

        if (flush_in) begin
            dirty_d = '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                tag_d[i] = '0;
            end
        end else if (issue_we) begin
            dirty_d[issue_reg] = 1'b1;
            tag_d[issue_reg]   = issue_tag;
        end

        for (int i = 0; i < NUM_REGS; i++) begin
            busy_d = busy_d + (REG_BIT+1)'(dirty_d[i]);
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
                tag_q[i]  <= '0;
            end
            dirty_q <= '0;
            busy_q  <= '0;
        end else if (rdy_in) begin
            regs_q  <= regs_d;
            tag_q   <= tag_d;
            dirty_q <= dirty_d;
            busy_q  <= busy_d;
        end
    end

    assign busy_count = busy_q;

    always_comb begin
        logic [REG_BIT-1:0] rsel;
        rsel        = '0;
        rd_val      = '0;
        rd_has_dep  = '0;
        rd_dep      = '0;
        rob_qry_tag = '0;
        for (int k = 0; k < NUM_READ; k++) begin
            rsel = rd_id[k*REG_BIT +: REG_BIT];
            rob_qry_tag[k*ROB_BIT +: ROB_BIT] = tag_q[rsel];
            if (rsel == '0) begin
                rd_val[k*XLEN +: XLEN] = '0;
            end else if (issue_valid && (issue_reg == rsel)) begin
                // The issuing instruction is older than the reader, so it becomes the producer.
                rd_has_dep[k]               = 1'b1;
                rd_dep[k*ROB_BIT +: ROB_BIT] = issue_tag;
            end else if (dirty_q[rsel] && commit_valid && (commit_reg == rsel)
                         && (commit_tag == tag_q[rsel])) begin
                rd_val[k*XLEN +: XLEN] = commit_data;
            end else if (dirty_q[rsel] && rob_qry_ready[k]) begin
                rd_val[k*XLEN +: XLEN] = rob_qry_value[k*XLEN +: XLEN];
            end else if (dirty_q[rsel]) begin
                rd_has_dep[k]               = 1'b1;
                rd_dep[k*ROB_BIT +: ROB_BIT] = tag_q[rsel];
            end else begin
                rd_val[k*XLEN +: XLEN] = regs_q[rsel];
            end
        end
    end

endmodule

// File: tb/tb_reg_rename_file.sv
// Randomized and directed bench for reg_rename_file against an array-based reference model.
module tb_reg_rename_file;

    localparam int XLEN = 32, NUM_REGS = 32, REG_BIT = 5, ROB_BIT = 4, NUM_READ = 2;

    logic                         clk_in = 1'b0;
    logic                         rst_in, rdy_in, flush_in;
    logic                         commit_valid, issue_valid;
    logic [REG_BIT-1:0]           commit_reg, issue_reg;
    logic [XLEN-1:0]              commit_data;
    logic [ROB_BIT-1:0]           commit_tag, issue_tag;
    logic [NUM_READ*REG_BIT-1:0]  rd_id;
    logic [NUM_READ*XLEN-1:0]     rd_val;
    logic [NUM_READ-1:0]          rd_has_dep;
    logic [NUM_READ*ROB_BIT-1:0]  rd_dep, rob_qry_tag;
    logic [NUM_READ-1:0]          rob_qry_ready;
    logic [NUM_READ*XLEN-1:0]     rob_qry_value;
    logic [REG_BIT:0]             busy_count;

    reg_rename_file #(
        .XLEN(XLEN), .NUM_REGS(NUM_REGS), .REG_BIT(REG_BIT), .ROB_BIT(ROB_BIT),
        .NUM_READ(NUM_READ)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .commit_valid(commit_valid), .commit_reg(commit_reg), .commit_data(commit_data),
        .commit_tag(commit_tag), .issue_valid(issue_valid), .issue_reg(issue_reg),
        .issue_tag(issue_tag), .rd_id(rd_id), .rd_val(rd_val), .rd_has_dep(rd_has_dep),
        .rd_dep(rd_dep), .rob_qry_tag(rob_qry_tag), .rob_qry_ready(rob_qry_ready),
        .rob_qry_value(rob_qry_value), .busy_count(busy_count)
    );

    always #5 clk_in = ~clk_in;

    int unsigned total = 0;
    int unsigned bad   = 0;

    // Reference state
    int unsigned m_regs  [NUM_REGS];
    int unsigned m_tag   [NUM_REGS];
    bit          m_dirty [NUM_REGS];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NUM_REGS; i++) begin
            m_regs[i] = 0; m_tag[i] = 0; m_dirty[i] = 0;
        end
    endfunction

    function automatic int unsigned model_busy();
        int unsigned n = 0;
        for (int i = 0; i < NUM_REGS; i++) n += m_dirty[i];
        return n;
    endfunction

    function automatic void model_clock();
        int unsigned cr = commit_reg, ir = issue_reg;
        if (!rdy_in) return;
        if (commit_valid && cr != 0) begin
            assert (m_dirty[cr]) else $error("commit to non-dirty register x%0d", cr);
            m_regs[cr] = commit_data;
            if (m_tag[cr] == commit_tag) begin
                m_dirty[cr] = 0; m_tag[cr] = 0;
            end
        end
        if (flush_in) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                m_dirty[i] = 0; m_tag[i] = 0;
            end
        end else if (issue_valid && ir != 0) begin
            m_dirty[ir] = 1; m_tag[ir] = issue_tag;
        end
    endfunction

    task automatic check_reads();
        for (int k = 0; k < NUM_READ; k++) begin
            int unsigned r = rd_id[k*REG_BIT +: REG_BIT];
            int unsigned ev = 0, ed = 0;
            bit eh = 0;
            if (r == 0) begin
                ev = 0;
            end else if (issue_valid && issue_reg == r) begin
                eh = 1; ed = issue_tag;
            end else if (m_dirty[r] && commit_valid && commit_reg == r && commit_tag == m_tag[r]) begin
                ev = commit_data;
            end else if (m_dirty[r] && rob_qry_ready[k]) begin
                ev = rob_qry_value[k*XLEN +: XLEN];
            end else if (m_dirty[r]) begin
                eh = 1; ed = m_tag[r];
            end else begin
                ev = m_regs[r];
            end
            check_eq($sformatf("val%0d x%0d", k, r), 64'(rd_val[k*XLEN +: XLEN]), 64'(ev));
            check_eq($sformatf("has_dep%0d x%0d", k, r), 64'(rd_has_dep[k]), 64'(eh));
            check_eq($sformatf("dep%0d x%0d", k, r), 64'(rd_dep[k*ROB_BIT +: ROB_BIT]), 64'(ed));
            check_eq($sformatf("qry%0d x%0d", k, r), 64'(rob_qry_tag[k*ROB_BIT +: ROB_BIT]),
                     64'(m_tag[r]));
        end
    endtask

    task automatic idle();
        rdy_in = 1; flush_in = 0; commit_valid = 0; commit_reg = 0; commit_data = 0;
        commit_tag = 0; issue_valid = 0; issue_reg = 0; issue_tag = 0;
        rob_qry_ready = 0; rob_qry_value = 0;
    endtask

    task automatic set_rd(input int unsigned p0, input int unsigned p1);
        rd_id = {REG_BIT'(p1), REG_BIT'(p0)};
    endtask

    // Inputs are set just after a rising edge; check reads, clock, then check busy_count.
    task automatic cyc();
        #1 check_reads();
        @(posedge clk_in);
        model_clock();
        #1 check_eq("busy_count", 64'(busy_count), 64'(model_busy()));
    endtask

    task automatic issue(input int unsigned r, input int unsigned t);
        idle(); issue_valid = 1; issue_reg = REG_BIT'(r); issue_tag = ROB_BIT'(t); cyc();
    endtask

    task automatic commit(input int unsigned r, input int unsigned t, input int unsigned d);
        idle(); commit_valid = 1; commit_reg = REG_BIT'(r); commit_tag = ROB_BIT'(t);
        commit_data = d; cyc();
    endtask

    task automatic rand_cycle();
        int unsigned dl[$];
        idle();
        rdy_in   = ($urandom_range(0, 9) != 0);
        flush_in = ($urandom_range(0, 19) == 0);
        for (int i = 1; i < NUM_REGS; i++) if (m_dirty[i]) dl.push_back(i);
        if (dl.size() != 0 && $urandom_range(0, 9) < 4) begin
            int unsigned cr = dl[$urandom_range(0, dl.size() - 1)];
            commit_valid = 1; commit_reg = REG_BIT'(cr); commit_data = $urandom;
            commit_tag = ($urandom_range(0, 4) != 0) ? ROB_BIT'(m_tag[cr]) : ROB_BIT'($urandom);
        end
        if ($urandom_range(0, 1) == 1) begin
            issue_valid = 1; issue_tag = ROB_BIT'($urandom);
            issue_reg = ($urandom_range(0, 1) == 1) ? REG_BIT'($urandom_range(0, 7))
                                                    : REG_BIT'($urandom);
        end
        set_rd($urandom_range(0, 9), ($urandom_range(0, 3) == 0) ? issue_reg : $urandom_range(0, 9));
        rob_qry_ready = NUM_READ'($urandom);
        rob_qry_value = {$urandom, $urandom};
        cyc();
    endtask

    initial begin
        rst_in = 0; idle(); set_rd(0, 0); model_reset();
        @(posedge clk_in); #1 rst_in = 1;

        // Reset state
        set_rd(5, 0); #1;
        check_eq("rst val x5", 64'(rd_val[31:0]), 64'd0);
        check_eq("rst has_dep x5", 64'(rd_has_dep[0]), 64'd0);
        check_eq("rst busy", 64'(busy_count), 64'd0);

        // Issue to x0 is discarded
        issue(0, 3);
        idle(); set_rd(0, 0); #1;
        check_eq("x0 val", 64'(rd_val[31:0]), 64'd0);
        check_eq("x0 busy", 64'(busy_count), 64'd0);

        // Issue x5 tag 2 with same-cycle read
        idle(); issue_valid = 1; issue_reg = 5; issue_tag = 2; set_rd(5, 0); #1;
        check_eq("issue fwd has_dep", 64'(rd_has_dep[0]), 64'd1);
        check_eq("issue fwd dep", 64'(rd_dep[3:0]), 64'd2);
        cyc();
        idle(); #1;
        check_eq("x5 wait has_dep", 64'(rd_has_dep[0]), 64'd1);
        check_eq("x5 wait dep", 64'(rd_dep[3:0]), 64'd2);
        check_eq("x5 busy", 64'(busy_count), 64'd1);
        rob_qry_ready = 2'b01; rob_qry_value[31:0] = 32'hDEAD; #1;
        check_eq("rob fwd val", 64'(rd_val[31:0]), 64'hDEAD);
        check_eq("rob fwd has_dep", 64'(rd_has_dep[0]), 64'd0);
        cyc();
        commit(5, 2, 32'hDEAD);

        // Overlapping writers of x7
        issue(7, 1);
        issue(7, 4);
        commit(7, 1, 32'h11);
        idle(); set_rd(0, 7); #1;
        check_eq("x7 still dep", 64'(rd_dep[7:4]), 64'd4);
        commit_valid = 1; commit_reg = 7; commit_tag = 4; commit_data = 32'h22; #1;
        check_eq("bypass val", 64'(rd_val[63:32]), 64'h22);
        check_eq("bypass has_dep", 64'(rd_has_dep[1]), 64'd0);
        cyc();
        idle(); #1;
        check_eq("x7 clean val", 64'(rd_val[63:32]), 64'h22);
        check_eq("x7 clean has_dep", 64'(rd_has_dep[1]), 64'd0);
        check_eq("x7 busy", 64'(busy_count), 64'd0);

        // Same-cycle commit and issue of x9
        issue(9, 6);
        idle(); commit_valid = 1; commit_reg = 9; commit_tag = 6; commit_data = 32'h99;
        issue_valid = 1; issue_reg = 9; issue_tag = 7; set_rd(9, 9); cyc();
        idle(); #1;
        check_eq("x9 dep", 64'(rd_dep[3:0]), 64'd7);
        check_eq("x9 busy", 64'(busy_count), 64'd1);

        // Flush with concurrent commit and issue
        issue(3, 1);
        issue(10, 2);
        idle(); flush_in = 1; commit_valid = 1; commit_reg = 3; commit_tag = 1;
        commit_data = 32'h33; issue_valid = 1; issue_reg = 4; issue_tag = 5; set_rd(3, 4); cyc();
        idle(); #1;
        check_eq("flush busy", 64'(busy_count), 64'd0);
        check_eq("flush x3 val", 64'(rd_val[31:0]), 64'h33);
        check_eq("flush x4 has_dep", 64'(rd_has_dep[1]), 64'd0);

        // rdy_in low freezes state
        idle(); rdy_in = 0; issue_valid = 1; issue_reg = 6; issue_tag = 3;
        commit_valid = 1; commit_reg = 3; commit_tag = 0; commit_data = 32'h77; cyc();
        idle(); set_rd(3, 6); #1;
        check_eq("frozen x3", 64'(rd_val[31:0]), 64'h33);
        check_eq("frozen x6", 64'(rd_has_dep[1]), 64'd0);

        for (int n = 0; n < 400; n++) rand_cycle();

        // Asynchronous reset between edges
        issue(12, 3);
        issue(13, 5);
        commit(13, 5, 32'h1313);
        idle(); set_rd(12, 13); #2 rst_in = 0; #1;
        model_reset();
        check_eq("arst busy", 64'(busy_count), 64'd0);
        check_eq("arst x12 has_dep", 64'(rd_has_dep[0]), 64'd0);
        check_eq("arst x13 val", 64'(rd_val[63:32]), 64'd0);
        @(posedge clk_in); #1 rst_in = 1;
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
